// File: rtl/demux_1to2_stream.sv
// rtl/demux_1to2_stream.sv - registered 1-to-2 stream demultiplexer with valid/ready handshaking
//
// Routes each accepted input beat into one of two single-entry output
// registers (A when sel=1, B when sel=0). Each branch drains on its own, so a
// stalled branch never holds back beats routed to the other one.
//
// Optional feature macro: DEMUX_PKT_LOCK_EN
//   defined   : the route is locked from the first beat of a packet until its
//               in_last beat; sel is ignored while locked and busy=1.
//   undefined : per-beat routing from sel; busy is tied to 0.
//
// Ports:
//   clk                 clock, rising edge
//   rst                 asynchronous, active-high reset
//   in_valid/in_ready   input handshake
//   in_data/in_last     input payload and end-of-packet flag
//   sel                 route select (1 -> A, 0 -> B)
//   a_valid/a_ready     branch A handshake
//   a_data/a_last       branch A payload
//   b_valid/b_ready     branch B handshake
//   b_data/b_last       branch B payload
//   busy                packet route is locked
module demux_1to2_stream #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  input  logic             in_last,
  input  logic             sel,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [width-1:0] a_data,
  output logic             a_last,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [width-1:0] b_data,
  output logic             b_last,
  output logic             busy
);

  logic route;
  logic accept;
  logic a_load;
  logic b_load;

`ifdef DEMUX_PKT_LOCK_EN
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   locked_sel;
  logic   locked_sel_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      locked_sel <= 1'b0;
    end else begin
      state      <= state_nxt;
      locked_sel <= locked_sel_nxt;
    end
  end

  // Next-state only; route is derived outside this block so that the
  // acceptance it feeds back does not form a loop through one process.
  always_comb begin
    state_nxt      = state;
    locked_sel_nxt = locked_sel;
    case (state)
      IDLE: begin
        // A single-beat packet (in_last=1) never leaves IDLE.
        if (accept && !in_last) begin
          state_nxt      = LOCKED;
          locked_sel_nxt = sel;
        end
      end
      LOCKED: begin
        if (accept && in_last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign route = (state == LOCKED) ? locked_sel : sel;
  assign busy  = (state == LOCKED);
`else
  assign route = sel;
  assign busy  = 1'b0;
`endif

  // A branch can take a beat when it is empty or is emptying this cycle.
  assign in_ready = !rst && (route ? (!a_valid || a_ready)
                                   : (!b_valid || b_ready));
  assign accept   = in_valid && in_ready;
  assign a_load   = accept && route;
  assign b_load   = accept && !route;

  // A refill takes priority over a drain, giving back-to-back beats without
  // a bubble; data is only written on a load, so it holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_data  <= '0;
      a_last  <= 1'b0;
    end else if (a_load) begin
      a_valid <= 1'b1;
      a_data  <= in_data;
      a_last  <= in_last;
    end else if (a_ready) begin
      a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_valid <= 1'b0;
      b_data  <= '0;
      b_last  <= 1'b0;
    end else if (b_load) begin
      b_valid <= 1'b1;
      b_data  <= in_data;
      b_last  <= in_last;
    end else if (b_ready) begin
      b_valid <= 1'b0;
    end
  end

endmodule
